alu_wb_stage: RTL and testbench
===============================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter: none; all widths fixed (16-bit data, 4-bit register index, 4-bit flags {N,Z,C,V}).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock domain.
REQ-004 in_valid  input  1  upstream ALU result valid this cycle.
REQ-005 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-006 in_result  input  16  ALU result.
REQ-007 in_flags  input  4  ALU flags {N,Z,C,V}; only C,V used.
REQ-008 in_sel  input  5  ALU operation select of this result.
REQ-009 in_dst  input  4  destination register index.
REQ-010 in_byte  input  1  byte operation (.B).
REQ-011 in_wr  input  1  result is written to destination (0 for CMP/BIT).
REQ-012 rf_we  output  1  register-file write request.
REQ-013 rf_waddr  output  4  write index.
REQ-014 rf_wdata  output  16  write data.
REQ-015 rf_ready  input  1  register file accepts write; transfer when rf_we && rf_ready.
REQ-016 sr_flags  output  4  architectural status {N,Z,C,V}; sr_flags[1] feeds ALU carry-in.
REQ-017 retired  output  16  count of entries accepted at input.

Function
REQ-018 Stage SHALL hold a 2-entry in-order buffer; states EMPTY, ONE, FULL.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL (registered state only, no rf_ready combinational path).
REQ-020 Transitions: accept-only +1, drain-only -1, accept+drain same cycle holds state; drain from EMPTY never occurs.
REQ-021 Only entries with in_wr=1 SHALL be stored; in_wr=0 accepts consume no buffer slot but still update flags and retired.
REQ-022 rf_we SHALL equal head-entry valid; rf_waddr/rf_wdata SHALL be head fields and remain stable while rf_we && !rf_ready.
REQ-023 Byte op: stored data = {8'h00, in_result[7:0]}; word op: in_result unchanged.
REQ-024 Flags SHALL update at input acceptance (zero latency to next ALU op via sr_flags next cycle).
REQ-025 N = bit 7 (byte) or bit 15 (word) of masked data; Z = masked data == 0; C = in_flags[1]; V = in_flags[0].
REQ-026 No flag update for in_sel in {00000 MOV, 01000 BIC, 01001 BIS, 01100}; all other sels update all four flags.
REQ-027 retired SHALL increment by 1 per accepted input, wrapping 16'hFFFF -> 16'h0000.
REQ-028 Accept in same cycle as drain in FULL SHALL not occur (in_ready=0); in ONE, simultaneous accept+drain SHALL place new entry at head next cycle.
REQ-029 Ordering: register-file writes SHALL occur in input acceptance order; no entry dropped or duplicated.

Reset
REQ-030 On rst_n=0 (asynchronous, any cycle incl. mid-drain): state EMPTY, rf_we=0, rf_waddr=0, rf_wdata=0, sr_flags=4'b0000, retired=0, in_ready=1 after release.
REQ-031 Buffered entries SHALL be discarded by reset; first edge after rst_n rises may accept input.

Verification
REQ-032 ADD word, result 16'h8000, C=1,V=1, dst 5, rf_ready=1 -> next cycle rf_we=1, waddr 5, wdata 8000; sr_flags=1011.
REQ-033 ADD.B result 16'h1200 -> wdata 0000, sr_flags Z=1,N=0; result 16'h0080 byte -> N=1.
REQ-034 rf_ready=0, three back-to-back in_wr=1 inputs -> two accepted, in_ready=0 in FULL, third held; release rf_ready -> writes in order, third accepted after drain.
REQ-035 CMP (in_wr=0, sel 00101, result 0) with prior sr 0000 -> no rf_we, sr_flags Z=1, retired +1.
REQ-036 MOV after flags 1010 -> sr_flags stays 1010; retired preset 16'hFFFF plus one accept -> 16'h0000.
REQ-037 Assert rst_n=0 while FULL and rf_ready=0 -> rf_we=0 immediately, sr_flags=0000, no pending writes after release.

Source files
------------

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback stage with a 2-entry in-order register-file write buffer,
// architectural status flags and a retired-instruction counter.
module alu_wb_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_result,
   input  logic [3:0]  in_flags,
   input  logic [4:0]  in_sel,
   input  logic [3:0]  in_dst,
   input  logic        in_byte,
   input  logic        in_wr,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   input  logic        rf_ready,
   output logic [3:0]  sr_flags,
   output logic [15:0] retired
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t      state_q, state_d;
   logic [3:0]  hd_addr_q, hd_addr_d, tl_addr_q, tl_addr_d;
   logic [15:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
   logic [3:0]  sr_q, sr_d;
   logic [15:0] ret_q, ret_d;
   logic        acc, push, pop, upd;
   logic [15:0] mdata;
   assign in_ready = state_q != FULL;
   assign rf_we    = state_q != EMPTY;
   assign rf_waddr = hd_addr_q;
   assign rf_wdata = hd_data_q;
   assign sr_flags = sr_q;
   assign retired  = ret_q;
   assign acc   = in_valid && in_ready;
   assign push  = acc && in_wr;
   assign pop   = rf_we && rf_ready;
   assign mdata = in_byte ? {8'h00, in_result[7:0]} : in_result;
   // MOV, BIC, BIS and sel 12 leave the status register untouched
   assign upd   = !(in_sel inside {5'd0, 5'd8, 5'd9, 5'd12});
   assign sr_d  = (acc && upd) ? {in_byte ? mdata[7] : mdata[15], mdata == 16'h0000, in_flags[1], in_flags[0]} : sr_q;
   assign ret_d = ret_q + {15'd0, acc};
   always_comb begin
      state_d   = state_q;
      hd_addr_d = hd_addr_q;
      hd_data_d = hd_data_q;
      tl_addr_d = tl_addr_q;
      tl_data_d = tl_data_q;
      if (state_q == EMPTY) begin
         if (push) begin
            state_d   = ONE;
            hd_addr_d = in_dst;
            hd_data_d = mdata;
         end
      end else if (state_q == ONE) begin
         // accept+drain: the new entry replaces the departing head
         if (push && pop) begin
            hd_addr_d = in_dst;
            hd_data_d = mdata;
         end else if (push) begin
            state_d   = FULL;
            tl_addr_d = in_dst;
            tl_data_d = mdata;
         end else if (pop) begin
            state_d = EMPTY;
         end
      end else if (pop) begin
         state_d   = ONE;
         hd_addr_d = tl_addr_q;
         hd_data_d = tl_data_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         hd_addr_q <= '0;
         hd_data_q <= '0;
         tl_addr_q <= '0;
         tl_data_q <= '0;
         sr_q      <= '0;
         ret_q     <= '0;
      end else begin
         state_q   <= state_d;
         hd_addr_q <= hd_addr_d;
         hd_data_q <= hd_data_d;
         tl_addr_q <= tl_addr_d;
         tl_data_q <= tl_data_d;
         sr_q      <= sr_d;
         ret_q     <= ret_d;
      end
   end
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: random and directed stimulus checked every cycle against a queue-based
// reference model, plus literal expectations for the documented scenarios.
module tb_alu_wb_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_byte = 1'b0, in_wr = 1'b0, rf_ready = 1'b0;
   logic [15:0] in_result = '0;
   logic [3:0]  in_flags = '0, in_dst = '0;
   logic [4:0]  in_sel = '0;
   logic        in_ready, rf_we;
   logic [3:0]  rf_waddr, sr_flags;
   logic [15:0] rf_wdata, retired;
   int          n_cmp = 0, n_err = 0;

   alu_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_flags(in_flags), .in_sel(in_sel), .in_dst(in_dst),
      .in_byte(in_byte), .in_wr(in_wr), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .rf_ready(rf_ready), .sr_flags(sr_flags), .retired(retired)
   );

   always #5 clk = ~clk;

   // reference model: pending writes as a queue of {addr,data}, flags and counter as plain values
   logic [19:0] m_q[$];
   logic [3:0]  m_sr = '0;
   logic [15:0] m_ret = '0;

   function automatic logic [3:0] model_flags(logic [15:0] r, logic b, logic [3:0] f, logic [4:0] s, logic [3:0] old);
      logic [15:0] d;
      d = b ? (r & 16'h00FF) : r;
      if (s == 5'd0 || s == 5'd8 || s == 5'd9 || s == 5'd12) return old;
      return {b ? d[7] : d[15], d == 16'h0000, f[1], f[0]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_sr  <= '0;
         m_ret <= '0;
      end else begin
         logic acc;
         acc = in_valid && (m_q.size() < 2);
         if (m_q.size() > 0 && rf_ready) void'(m_q.pop_front());
         if (acc) begin
            if (in_wr) m_q.push_back({in_dst, in_byte ? (in_result & 16'h00FF) : in_result});
            m_sr  <= model_flags(in_result, in_byte, in_flags, in_sel, m_sr);
            m_ret <= m_ret + 16'd1;
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", in_ready, m_q.size() < 2);
         chk("rf_we", rf_we, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("rf_waddr", rf_waddr, m_q[0][19:16]);
            chk("rf_wdata", rf_wdata, m_q[0][15:0]);
         end
         chk("sr_flags", sr_flags, m_sr);
         chk("retired", retired, m_ret);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic [15:0] r, logic [3:0] f, logic [4:0] s, logic [3:0] d, logic b, logic w);
      in_valid = v; in_result = r; in_flags = f; in_sel = s; in_dst = d; in_byte = b; in_wr = w;
   endtask

   initial begin
      int n;
      repeat (3) cyc();
      chk("rst rf_we", rf_we, 0);
      chk("rst waddr", rf_waddr, 0);
      chk("rst wdata", rf_wdata, 0);
      chk("rst sr", sr_flags, 0);
      chk("rst retired", retired, 0);
      chk("rst in_ready", in_ready, 1);
      rst_n = 1'b1;
      rf_ready = 1'b1;
      drive(1, 16'h8000, 4'b0011, 5'd2, 4'd5, 0, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("add rf_we", rf_we, 1);
      chk("add waddr", rf_waddr, 5);
      chk("add wdata", rf_wdata, 16'h8000);
      chk("add sr", sr_flags, 4'b1011);
      drive(1, 16'h1200, 4'b0000, 5'd2, 4'd3, 1, 1);
      cyc();
      chk("addb wdata", rf_wdata, 16'h0000);
      chk("addb sr", sr_flags, 4'b0100);
      drive(1, 16'h0080, 4'b0000, 5'd2, 4'd4, 1, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("addb80 wdata", rf_wdata, 16'h0080);
      chk("addb80 sr", sr_flags, 4'b1000);
      cyc();
      rf_ready = 1'b0;
      drive(1, 16'h1111, 0, 5'd2, 4'd1, 0, 1);
      cyc();
      drive(1, 16'h2222, 0, 5'd2, 4'd2, 0, 1);
      cyc();
      drive(1, 16'h3333, 0, 5'd2, 4'd3, 0, 1);
      chk("full in_ready", in_ready, 0);
      cyc();
      cyc();
      chk("held waddr", rf_waddr, 1);
      chk("held retired", retired, 5);
      rf_ready = 1'b1;
      cyc();
      chk("drain1 waddr", rf_waddr, 2);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drain2 waddr", rf_waddr, 3);
      chk("drain2 wdata", rf_wdata, 16'h3333);
      chk("third retired", retired, 6);
      cyc();
      drive(1, 16'h0001, 4'b0000, 5'd2, 4'd0, 0, 0);
      cyc();
      chk("pre-cmp sr", sr_flags, 4'b0000);
      drive(1, 16'h0000, 4'b0000, 5'd5, 4'd7, 0, 0);
      cyc();
      chk("cmp rf_we", rf_we, 0);
      chk("cmp sr", sr_flags, 4'b0100);
      chk("cmp retired", retired, 8);
      drive(1, 16'h8000, 4'b0010, 5'd2, 4'd0, 0, 0);
      cyc();
      drive(1, 16'h0000, 4'b0000, 5'd0, 4'd9, 0, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("mov sr", sr_flags, 4'b1010);
      chk("mov wdata", rf_wdata, 16'h0000);
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] s;
         s = ($urandom_range(0, 3) == 0) ? 5'(($urandom_range(0, 3) == 0) ? 0 : 8 + $urandom_range(0, 1) * ($urandom_range(0, 1) ? 4 : 1)) : 5'($urandom);
         drive($urandom_range(0, 2) != 0, 16'($urandom_range(0, 7) == 0 ? 0 : $urandom), 4'($urandom), s,
               4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
         rf_ready = $urandom_range(0, 2) != 0;
         cyc();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      rf_ready = 1'b1;
      repeat (3) cyc();
      n = 16'hFFFF - m_ret;
      drive(1, 16'h0000, 4'b0000, 5'd0, 4'd0, 0, 0);
      repeat (n) cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("ret ffff", retired, 16'hFFFF);
      drive(1, 16'h0000, 4'b0000, 5'd0, 4'd0, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("ret wrap", retired, 16'h0000);
      rf_ready = 1'b0;
      drive(1, 16'hAAAA, 4'b0011, 5'd2, 4'd6, 0, 1);
      cyc();
      drive(1, 16'hBBBB, 4'b0011, 5'd2, 4'd7, 0, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("pre-rst full", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async rf_we", rf_we, 0);
      chk("async sr", sr_flags, 0);
      chk("async retired", retired, 0);
      chk("async in_ready", in_ready, 1);
      cyc();
      rst_n = 1'b1;
      rf_ready = 1'b1;
      repeat (3) begin
         cyc();
         chk("post-rst rf_we", rf_we, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
